// File: rtl/mux4_1behavioral.sv
// Behavioural 4:1 lane multiplexer with zero-extended output.
// The output is either a reset-defined flop bank or a pure combinational path.
module mux4_1behavioral #(
    parameter int LANE_W     = 1,
    parameter bit REGISTERED = 1'b1
) (
    input  logic [4*LANE_W-1:0] d,
    input  logic [1:0]          s,
    output logic [4*LANE_W-1:0] o,
    input  logic                clk,
    input  logic                rst_n
);

    logic [LANE_W-1:0]   sel_s;
    logic [4*LANE_W-1:0] next_o_s;

    // Lane select; unknown select values resolve to zero rather than a latch
    always_comb begin
        sel_s = {LANE_W{1'b0}};
        case (s)
            2'd0:    sel_s = d[0*LANE_W +: LANE_W];
            2'd1:    sel_s = d[1*LANE_W +: LANE_W];
            2'd2:    sel_s = d[2*LANE_W +: LANE_W];
            2'd3:    sel_s = d[3*LANE_W +: LANE_W];
            default: sel_s = {LANE_W{1'b0}};
        endcase
    end

    // Upper three lanes of the output word are never driven nonzero
    always_comb begin
        next_o_s = {{(3*LANE_W){1'b0}}, sel_s};
    end

    generate
        if (REGISTERED) begin : g_reg
            logic [4*LANE_W-1:0] o_r;

            // Output flop bank: loads every cycle, cleared asynchronously by rst_n
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_r <= {(4*LANE_W){1'b0}};
                end else begin
                    o_r <= next_o_s;
                end
            end

            assign o = o_r;
        end else begin : g_comb
            // Clock and reset have no function in the combinational variant
            logic unused_s;
            assign unused_s = clk & rst_n;
            assign o        = next_o_s;
        end
    endgenerate

endmodule

// File: tb/tb_mux4_1behavioral.sv
// Directed bench: registered 1-bit lanes, registered 4-bit lanes, combinational variant.
module tb_mux4_1behavioral;

    logic        clk;
    logic        rst_n;
    logic [3:0]  d;
    logic [1:0]  s;
    logic [3:0]  o;
    logic [15:0] d_w;
    logic [1:0]  s_w;
    logic [15:0] o_w;
    logic [3:0]  d_c;
    logic [1:0]  s_c;
    logic [3:0]  o_c;

    int n_checks;
    int n_fails;

    typedef struct {
        logic [3:0] d;
        logic [1:0] s;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    mux4_1behavioral #(.LANE_W(1), .REGISTERED(1'b1)) dut (
        .d(d), .s(s), .o(o), .clk(clk), .rst_n(rst_n)
    );

    mux4_1behavioral #(.LANE_W(4), .REGISTERED(1'b1)) dut_w (
        .d(d_w), .s(s_w), .o(o_w), .clk(clk), .rst_n(rst_n)
    );

    mux4_1behavioral #(.LANE_W(1), .REGISTERED(1'b0)) dut_c (
        .d(d_c), .s(s_c), .o(o_c), .clk(clk), .rst_n(rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fails  = 0;
        clk   = 1'b0;
        rst_n = 1'b1;
        d     = 4'b1111;
        s     = 2'd3;
        d_w   = 16'hA5C3;
        s_w   = 2'd2;
        d_c   = 4'b0010;
        s_c   = 2'd1;

        // Directed vectors with hand-computed results
        vecs.push_back('{4'd5,  2'd2, 4'b0001});
        vecs.push_back('{4'd15, 2'd3, 4'b0001});
        vecs.push_back('{4'd6,  2'd1, 4'b0001});
        vecs.push_back('{4'd6,  2'd0, 4'b0000});
        // Exhaustive sweep; expected bit taken by shifting, not indexing
        for (int dv = 0; dv < 16; dv++) begin
            for (int sv = 0; sv < 4; sv++) begin
                v.d   = 4'(dv);
                v.s   = 2'(sv);
                v.exp = 4'((dv >> sv) & 1);
                vecs.push_back(v);
            end
        end

        // Reset asserted before any clock edge clears outputs immediately
        #1 rst_n = 1'b0;
        #1;
        check("reset_immediate", {12'h000, o}, 16'h0000);
        check("reset_immediate_wide", o_w, 16'h0000);
        check("comb_ignores_reset", {12'h000, o_c}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_held", {12'h000, o}, 16'h0000);
        end

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("reset_release", {12'h000, o}, 16'h0001);
        check("wide_s2", o_w, 16'h0005);

        // Wide lanes
        @(negedge clk);
        s_w = 2'd3;
        tick();
        check("wide_s3", o_w, 16'h000A);
        @(negedge clk);
        s_w = 2'd0;
        tick();
        check("wide_s0", o_w, 16'h0003);
        @(negedge clk);
        s_w = 2'd1;
        tick();
        check("wide_s1", o_w, 16'h000C);

        // Table: registered result one edge later; combinational result before the edge
        foreach (vecs[i]) begin
            @(negedge clk);
            d   = vecs[i].d;
            s   = vecs[i].s;
            d_c = vecs[i].d;
            s_c = vecs[i].s;
            #1;
            check("comb_vec", {12'h000, o_c}, {12'h000, vecs[i].exp});
            tick();
            check("reg_vec", {12'h000, o}, {12'h000, vecs[i].exp});
        end

        // Combinational select change without any clock edge
        @(negedge clk);
        d_c = 4'b0010;
        s_c = 2'd0;
        #1;
        check("comb_s0", {12'h000, o_c}, 16'h0000);
        s_c = 2'd1;
        #1;
        check("comb_s1", {12'h000, o_c}, 16'h0001);

        // Mid-operation reset pulse between edges
        @(negedge clk);
        d = 4'b1000;
        s = 2'd3;
        tick();
        check("mid_before", {12'h000, o}, 16'h0001);
        #1 rst_n = 1'b0;
        #1;
        check("mid_async_clear", {12'h000, o}, 16'h0000);
        check("mid_comb_unaffected", {12'h000, o_c}, 16'h0001);
        tick();
        check("mid_held_over_edge", {12'h000, o}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_release_no_edge", {12'h000, o}, 16'h0000);
        tick();
        check("mid_after_release", {12'h000, o}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
